sec32_check_encoder: RTL

Pipelined check-bit generator for the 32-bit single-error-correcting datapath. It accepts 32-bit data words over a valid/ready handshake and emits each word with the 8 check bits that the SEC corrector (enable input high) expects, so that an uncorrupted word produces an all-zero syndrome and passes through uncorrected. It sits on the write/transmit side of the channel. It also provides a one-shot single-bit error injector for bench and system self-test of the corrector.

---
 rtl/sec32_check_encoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sec32_check_encoder.sv
// sec32_check_encoder: two-stage check-bit generator for the 32-bit SEC
// datapath, with a valid/ready handshake on both sides, a one-shot single-bit
// error injector for corrector self-test, and a count of emitted words.
module sec32_check_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_check,
  input  logic             inj_req,
  input  logic [5:0]       inj_bit,
  output logic             inj_armed,
  output logic [CNT_W-1:0] word_cnt
);

  // Combine nibble-group parities (g) with column parities (lh: L0..L3, H0..H3)
  // into the eight check bits the corrector expects.
  function automatic logic [7:0] check_bits(input logic [7:0] g, input logic [7:0] lh);
    logic [7:0] c;
    c[0] = g[4] ^ g[5] ^ lh[0];
    c[1] = g[6] ^ g[7] ^ lh[1];
    c[2] = g[4] ^ g[6] ^ lh[2];
    c[3] = g[5] ^ g[7] ^ lh[3];
    c[4] = g[0] ^ g[1] ^ lh[4];
    c[5] = g[2] ^ g[3] ^ lh[5];
    c[6] = g[0] ^ g[2] ^ lh[6];
    c[7] = g[1] ^ g[3] ^ lh[7];
    return c;
  endfunction

  // One-hot flip over {check, data}; idx is always 0..39 when en is set.
  function automatic logic [39:0] flip_mask(input logic en, input logic [5:0] idx);
    logic [39:0] m;
    m = '0;
    if (en) m = 40'd1 << idx;
    return m;
  endfunction

  logic             vld_p1;
  logic [31:0]      data_p1;
  logic [7:0]       grp_p1;
  logic [7:0]       col_p1;
  logic             tag_p1;
  logic [5:0]       tag_bit_p1;

  logic             vld_p2;
  logic [31:0]      data_p2;
  logic [7:0]       check_p2;

  logic             armed;
  logic [5:0]       armed_bit;
  logic [CNT_W-1:0] cnt;

  logic [7:0]       grp;
  logic [7:0]       col;
  logic             s2_free;
  logic             accept;
  logic             s2_load;
  logic             xfer;
  logic             req_ok;
  logic             eff_armed;
  logic [5:0]       eff_bit;

  // Handshake: stage 2 frees when empty or draining; stage 1 can take a word
  // when empty or when its word moves on this cycle. Reset blocks both sides.
  assign s2_free   = !vld_p2 || out_ready;
  assign in_ready  = !rst && (!vld_p1 || s2_free);
  assign accept    = in_valid && in_ready;
  assign s2_load   = vld_p1 && s2_free;
  assign out_valid = vld_p2 && !rst;
  assign xfer      = vld_p2 && out_ready && !rst;

  // A valid request takes effect in its own cycle, so a word accepted
  // alongside the request already carries the injection.
  assign req_ok    = inj_req && (inj_bit <= 6'd39);
  assign eff_armed = armed || req_ok;
  assign eff_bit   = req_ok ? inj_bit : armed_bit;

  assign out_data  = data_p2;
  assign out_check = check_p2;
  assign inj_armed = armed;
  assign word_cnt  = cnt;

  // Nibble-group and column parities of the incoming word.
  always_comb begin
    grp = '0;
    col = '0;
    for (int g = 0; g < 8; g++) grp[g] = ^in_data[4*g +: 4];
    for (int j = 0; j < 4; j++) begin
      col[j]   = in_data[j]    ^ in_data[j+4]  ^ in_data[j+8]  ^ in_data[j+12];
      col[4+j] = in_data[16+j] ^ in_data[20+j] ^ in_data[24+j] ^ in_data[28+j];
    end
  end

  // Pipeline occupancy, injector arming and the transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      armed  <= 1'b0;
      cnt    <= '0;
    end else begin
      if (accept)       vld_p1 <= 1'b1;
      else if (s2_load) vld_p1 <= 1'b0;
      if (s2_load)        vld_p2 <= 1'b1;
      else if (out_ready) vld_p2 <= 1'b0;
      armed <= accept ? 1'b0 : eff_armed;
      if (xfer) cnt <= cnt + 1'b1;
    end
  end

  // Latest requested bit index; only meaningful while armed.
  always_ff @(posedge clk) begin
    if (req_ok) armed_bit <= inj_bit;
  end

  // ---- stage 1: capture word, parities and injection tag ----
  // Capture on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1    <= in_data;
      grp_p1     <= grp;
      col_p1     <= col;
      tag_p1     <= eff_armed;
      tag_bit_p1 <= eff_bit;
    end
  end

  // ---- stage 2: check bits, injection, output register ----
  // Output register; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p2  <= '0;
      check_p2 <= '0;
    end else if (s2_load) begin
      {check_p2, data_p2} <= {check_bits(grp_p1, col_p1), data_p1} ^ flip_mask(tag_p1, tag_bit_p1);
    end
  end

endmodule
